// File: rtl/opr_sequencer_pkg.sv
// opr_sequencer_pkg -- shared definitions for the PDP-8 operate-instruction
// sequencer: FSM state encoding, instruction group selection and the bit
// positions of the micro-op fields inside the low 9 bits of an OPR word.
//
// Bit numbering follows ir[8:0], where ir[8] is the group select and ir[0]
// is the group 2/3 split (and IAC in group 1).
package opr_sequencer_pkg;

    localparam int WORD_W = 12;

    // One state per micro-op slot; every group walks all four slots.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4
    } opr_state_t;

    typedef enum logic [1:0] {
        GRP_1 = 2'd0,
        GRP_2 = 2'd1,
        GRP_3 = 2'd2
    } opr_group_t;

    // Group select fields
    localparam int IR_GRP   = 8;
    localparam int IR_SPLIT = 0;

    // Group 1 fields
    localparam int IR_CLA = 7;
    localparam int IR_CLL = 6;
    localparam int IR_CMA = 5;
    localparam int IR_CML = 4;
    localparam int IR_RAR = 3;
    localparam int IR_RAL = 2;
    localparam int IR_BSW = 1;   // doubles a rotate, or byte swap on its own
    localparam int IR_IAC = 0;

    // Group 2 fields (IR_CLA shared)
    localparam int IR_SMA = 6;
    localparam int IR_SZA = 5;
    localparam int IR_SNL = 4;
    localparam int IR_REV = 3;   // inverts the skip sense
    localparam int IR_OSR = 2;
    localparam int IR_HLT = 1;

    // Group 3 fields (IR_CLA shared)
    localparam int IR_MQA = 6;
    localparam int IR_MQL = 4;

    function automatic opr_group_t decode_group(input logic grp_bit, input logic split_bit);
        if (!grp_bit)
            return GRP_1;
        else if (!split_bit)
            return GRP_2;
        else
            return GRP_3;
    endfunction

endpackage

// File: rtl/opr_rotate.sv
// opr_rotate -- combinational slot-4 datapath for group 1 operate
// instructions: rotates the 13-bit {L,AC} word or swaps the AC halves.
//
// Ports:
//   word   in  13  {L, AC[11:0]} entering slot 4
//   code   in   3  ir[3:1] = {RAR, RAL, BSW}
//   result out 13  {L, AC} leaving slot 4
//
// code[2:1]: 10 rotate right, 01 rotate left, 00 with code[0] swaps
// AC[11:6] with AC[5:0] (L untouched), 11 leaves the word alone.
// code[0] doubles a rotate to two positions.
module opr_rotate (
    input  logic [12:0] word,
    input  logic [2:0]  code,
    output logic [12:0] result
);

    always_comb begin
        result = word;
        case (code[2:1])
            2'b10: result = code[0] ? {word[1:0], word[12:2]}
                                    : {word[0], word[12:1]};
            2'b01: result = code[0] ? {word[10:0], word[12:11]}
                                    : {word[11:0], word[12]};
            2'b00: if (code[0]) result = {word[12], word[5:0], word[11:6]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/opr_sequencer.sv
// opr_sequencer -- executes one PDP-8 operate (OPR) instruction as a fixed
// four-slot micro-op sequence: IDLE -> S1 -> S2 -> S3 -> S4 -> IDLE.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start                 one-cycle request, honoured only while idle
//   ir[8:0]               low bits of the OPR word
//   ac_in, link_in, mq_in operands, sampled with start
//   sr                    switch register, sampled with start
//   ac_out, link_out,     working registers; valid from the done pulse
//   mq_out                until the next accepted start
//   busy                  high in S1..S4
//   done                  one-cycle pulse in the cycle after S4
//   skip, halt            PC+1 / stop requests (group 2 only)
module opr_sequencer
    import opr_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  ir,
    input  logic [11:0] ac_in,
    input  logic        link_in,
    input  logic [11:0] mq_in,
    input  logic [11:0] sr,
    output logic [11:0] ac_out,
    output logic        link_out,
    output logic [11:0] mq_out,
    output logic        busy,
    output logic        done,
    output logic        skip,
    output logic        halt
);

    opr_state_t state, state_nxt;

    logic [8:0]        ir_q;
    logic [WORD_W-1:0] ac_q, mq_q, sr_q;
    logic              link_q, skip_q, halt_q, done_q;

    logic [WORD_W-1:0] ac_nxt, mq_nxt;
    logic              link_nxt, skip_nxt, halt_nxt;

    logic              accept;
    opr_group_t        grp;
    logic              skip_cond;
    logic [12:0]       rot_result;

    assign accept = (state == ST_IDLE) && start;
    assign grp    = decode_group(ir_q[IR_GRP], ir_q[IR_SPLIT]);

    // Skip test only ever runs in S1, so ac_q/link_q still hold the
    // operands captured with start.
    assign skip_cond = (ir_q[IR_SMA] & ac_q[WORD_W-1])
                     | (ir_q[IR_SZA] & (ac_q == '0))
                     | (ir_q[IR_SNL] & link_q);

    opr_rotate u_rotate (
        .word   ({link_q, ac_q}),
        .code   (ir_q[3:1]),
        .result (rot_result)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_S1;
            ST_S1:   state_nxt = ST_S2;
            ST_S2:   state_nxt = ST_S3;
            ST_S3:   state_nxt = ST_S4;
            ST_S4:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state != ST_IDLE);
        done     = done_q;
        ac_out   = ac_q;
        link_out = link_q;
        mq_out   = mq_q;
        skip     = skip_q;
        halt     = halt_q;
    end

    // ---------------- micro-op datapath ----------------
    always_comb begin
        ac_nxt   = ac_q;
        link_nxt = link_q;
        mq_nxt   = mq_q;
        skip_nxt = skip_q;
        halt_nxt = halt_q;

        if (accept) begin
            ac_nxt   = ac_in;
            link_nxt = link_in;
            mq_nxt   = mq_in;
            skip_nxt = 1'b0;
            halt_nxt = 1'b0;
        end else begin
            case (state)
                ST_S1: begin
                    case (grp)
                        GRP_1: begin
                            if (ir_q[IR_CLA]) ac_nxt   = '0;
                            if (ir_q[IR_CLL]) link_nxt = 1'b0;
                        end
                        GRP_2: skip_nxt = ir_q[IR_REV] ? ~skip_cond : skip_cond;
                        GRP_3: if (ir_q[IR_CLA]) ac_nxt = '0;
                        default: ;
                    endcase
                end
                ST_S2: begin
                    case (grp)
                        GRP_1: begin
                            if (ir_q[IR_CMA]) ac_nxt   = ~ac_q;
                            if (ir_q[IR_CML]) link_nxt = ~link_q;
                        end
                        GRP_2: if (ir_q[IR_CLA]) ac_nxt = '0;
                        GRP_3: begin
                            // MQA and MQL together exchange AC and MQ.
                            ac_nxt = (ir_q[IR_MQL] ? '0 : ac_q)
                                   | (ir_q[IR_MQA] ? mq_q : '0);
                            if (ir_q[IR_MQL]) mq_nxt = ac_q;
                        end
                        default: ;
                    endcase
                end
                ST_S3: begin
                    case (grp)
                        // 13-bit increment: carry out of AC lands in L.
                        GRP_1: if (ir_q[IR_IAC]) {link_nxt, ac_nxt} = {link_q, ac_q} + 13'd1;
                        GRP_2: if (ir_q[IR_OSR]) ac_nxt = ac_q | sr_q;
                        default: ;
                    endcase
                end
                ST_S4: begin
                    case (grp)
                        GRP_1: {link_nxt, ac_nxt} = rot_result;
                        GRP_2: halt_nxt = ir_q[IR_HLT];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q   <= '0;
            sr_q   <= '0;
            ac_q   <= '0;
            link_q <= 1'b0;
            mq_q   <= '0;
            skip_q <= 1'b0;
            halt_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (accept) begin
                ir_q <= ir;
                sr_q <= sr;
            end
            ac_q   <= ac_nxt;
            link_q <= link_nxt;
            mq_q   <= mq_nxt;
            skip_q <= skip_nxt;
            halt_q <= halt_nxt;
            done_q <= (state == ST_S4);
        end
    end

endmodule

// File: doc/opr_sequencer.md
OPR_SEQUENCER -- requirements
Module: opr_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have port: start  input  1  one-cycle request to execute the operate instruction in ir.
REQ-004 SHALL have port: ir  input  9  low 9 bits of the OPR instruction; ir[8] selects group, ir[0] splits group 2/3.
REQ-005 SHALL have ports: ac_in 12, link_in 1, mq_in 12, sr 12, all input: operands and switch register, sampled on start.
REQ-006 SHALL have ports: ac_out 12, link_out 1, mq_out 12, all output: results, registered.
REQ-007 SHALL have ports: busy, done, skip, halt, all output 1: sequence active; one-cycle completion pulse; PC+1 request; stop request.
REQ-008 SHALL use a single clock; reset is asynchronous and active-high; the ports are named clk and reset.

Function
REQ-009 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-010 On acceptance SHALL latch ir, ac_in, link_in, mq_in, sr into working registers; busy SHALL rise next cycle.
REQ-011 FSM states SHALL be IDLE -> S1 -> S2 -> S3 -> S4 -> IDLE, one cycle each, unconditional for all groups.
REQ-012 done SHALL pulse high for exactly one cycle, in the cycle after S4; ac_out/link_out/mq_out/skip/halt SHALL be valid and held from then until the next accepted start.
REQ-013 Group 1 (ir[8]=0): S1 clear AC if ir[7], clear L if ir[6]; S2 complement AC if ir[5], complement L if ir[4]; S3 {L,AC}+1 if ir[0] (13-bit wrap, carry into L); S4 rotate.
REQ-014 Group 1 S4: ir[3] alone rotates {L,AC} right; ir[2] alone rotates left; ir[1] doubles either (two positions); ir[1] with ir[3:2]=0 swaps AC[11:6]/AC[5:0], L unchanged; ir[3]&ir[2] both set SHALL leave AC and L unchanged.
REQ-015 Group 2 (ir[8]=1, ir[0]=0): S1 evaluate skip on the AC/L latched at start: cond = (ir[6]&AC[11]) | (ir[5]&AC==0) | (ir[4]&L); skip = ir[3] ? ~cond : cond.
REQ-016 Group 2 S2 clears AC if ir[7]; S3 ORs sr into AC if ir[2]; S4 sets halt if ir[1]; L unchanged.
REQ-017 Group 2 ir[3]=1 with ir[6:4]=0 SHALL yield skip=1 (unconditional skip).
REQ-018 Group 3 (ir[8]=1, ir[0]=1): S1 clears AC if ir[7]; S2 with MQA=ir[6], MQL=ir[4]: AC <= (MQL ? 0 : AC) | (MQA ? MQ : 0), MQ <= MQL ? AC : MQ, using the AC after S1; both set SHALL swap AC and MQ.
REQ-019 Group 3 S3/S4 SHALL be no-ops; ir[5] and ir[3:1] (EAE codes) SHALL NOT alter state; L unchanged.
REQ-020 skip and halt SHALL be 0 for groups 1 and 3.
REQ-021 All arithmetic SHALL be modulo 2^12 on AC, 2^13 on {L,AC}; AC[11] is the sign bit.

Reset
REQ-022 reset SHALL force IDLE and busy=done=skip=halt=0, ac_out=mq_out=12'o0000, link_out=0, immediately and asynchronously.
REQ-023 reset asserted mid-sequence SHALL abort without a done pulse; first start after reset release SHALL be accepted normally.

Structure
REQ-024 FSM state encodings and group-select constants SHALL live in the shared pdp8 definitions include.
REQ-025 The S4 rotate/swap datapath SHALL be a combinational sub-module opr_rotate (13-bit in, ir[3:1], 13-bit out).

Verification
REQ-026 G1 ir=9'o301 (CLA CLL IAC), ac=7777, L=1 -> done 5 cycles after start, ac_out=0001, link_out=0.
REQ-027 G1 ir=9'o041 (CMA IAC) ac=0000 L=0 -> ac_out=0000, link_out=1 (wrap carry); ir=9'o002 (BSW) ac=0077 -> ac_out=7700.
REQ-028 G2 ir=9'o440 (SZA) ac=0000 -> skip=1; ir=9'o450 (SNA) ac=0000 -> skip=0; ir=9'o410 (SKP) -> skip=1.
REQ-029 G2 ir=9'o606 (CLA OSR HLT) ac=1234 sr=4321 -> ac_out=4321, halt=1.
REQ-030 G3 ir=9'o521 (MQA MQL) ac=1111 mq=2222 -> ac_out=2222, mq_out=1111; start held high throughout -> only one done per 5 cycles.
REQ-031 reset pulsed in S2 -> outputs zero at once, no done; next start completes normally.
